context_access_ctrl: RTL

- Sequences all accesses to the JPEG-LS context memory bank (A/B/C/N/Nn arrays, one shared address per access).
- After reset or a new-scan command, sweeps every context and writes its initial value. Then it serves context fetches from the prediction stage and write-backs from the context-update stage.
- Resolves the one read/write hazard the two-port memory does not cover: a read and a write to the same context in the same cycle.
- Sits between the modeling pipeline and the ContextMemory instance; it drives that instance's read, write[1:0], Q_Read, Q_Write and *_Write pins.

---
 rtl/context_access_ctrl_if.sv | 38 +++
 rtl/context_access_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/context_access_ctrl_if.sv
// Context memory bus: read/write ports between context_access_ctrl (master)
// and the ContextMemory instance (slave).
interface context_access_ctrl_if #(
    parameter int Q_length   = 9,
    parameter int A_length   = 16,
    parameter int B_length   = 7,
    parameter int C_length   = 8,
    parameter int N_length   = 7,
    parameter int Nn_length  = 7,
    parameter int Context_rw = 2
);
    logic                  mem_read;
    logic [Q_length-1:0]   mem_Q_Read;
    logic [Context_rw-1:0] mem_write;
    logic [Q_length-1:0]   mem_Q_Write;
    logic [A_length-1:0]   mem_A_Write;
    logic [B_length-1:0]   mem_B_Write;
    logic [C_length-1:0]   mem_C_Write;
    logic [N_length-1:0]   mem_N_Write;
    logic [Nn_length-1:0]  mem_Nn_Write;
    logic [A_length-1:0]   mem_A_Read;
    logic [B_length-1:0]   mem_B_Read;
    logic [C_length-1:0]   mem_C_Read;
    logic [N_length-1:0]   mem_N_Read;
    logic [Nn_length-1:0]  mem_Nn_Read;

    modport master (
        output mem_read, mem_Q_Read, mem_write, mem_Q_Write,
               mem_A_Write, mem_B_Write, mem_C_Write, mem_N_Write, mem_Nn_Write,
        input  mem_A_Read, mem_B_Read, mem_C_Read, mem_N_Read, mem_Nn_Read
    );

    modport slave (
        input  mem_read, mem_Q_Read, mem_write, mem_Q_Write,
               mem_A_Write, mem_B_Write, mem_C_Write, mem_N_Write, mem_Nn_Write,
        output mem_A_Read, mem_B_Read, mem_C_Read, mem_N_Read, mem_Nn_Read
    );
endinterface

// File: rtl/context_access_ctrl.sv
// JPEG-LS context memory sequencer: init sweep, fetch/write-back arbitration.
// Optional macro CTX_FWD_EN: forward same-cycle same-context updates instead of stalling.
module context_access_ctrl #(
    parameter int Q_length   = 9,
    parameter int A_length   = 16,
    parameter int B_length   = 7,
    parameter int C_length   = 8,
    parameter int N_length   = 7,
    parameter int Nn_length  = 7,
    parameter int Context_rw = 2,
    parameter int NUM_CTX    = 367,
    parameter int A_INIT     = 4,
    parameter int N_INIT     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  scan_start,
    output logic                  init_done,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [Q_length-1:0]   req_q,
    input  logic                  upd_valid,
    input  logic [Q_length-1:0]   upd_q,
    input  logic [Context_rw-1:0] upd_mask,
    input  logic [A_length-1:0]   upd_A,
    input  logic [B_length-1:0]   upd_B,
    input  logic [C_length-1:0]   upd_C,
    input  logic [N_length-1:0]   upd_N,
    input  logic [Nn_length-1:0]  upd_Nn,
    output logic                  ctx_valid,
    output logic [Q_length-1:0]   ctx_q,
    output logic [A_length-1:0]   ctx_A,
    output logic [B_length-1:0]   ctx_B,
    output logic [C_length-1:0]   ctx_C,
    output logic [N_length-1:0]   ctx_N,
    output logic [Nn_length-1:0]  ctx_Nn,
    context_access_ctrl_if.master mem
);
    localparam logic [Q_length-1:0]   LAST_Q   = Q_length'(NUM_CTX - 1);
    localparam logic [Context_rw-1:0] MASK_ALL = {Context_rw{1'b1}};

    typedef enum logic [0:0] {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

    state_t                state_r, state_nxt_s;
    logic [Q_length-1:0]   cnt_r, cnt_nxt_s;
    logic                  init_done_r;
    logic                  ctx_valid_r;
    logic [Q_length-1:0]   ctx_q_r;
    logic                  hazard_s, ready_s, accept_s;
    logic [Context_rw-1:0] wr_code_s;
    logic [Q_length-1:0]   wr_q_s;
    logic [A_length-1:0]   wr_A_s, ctx_A_s;
    logic [B_length-1:0]   wr_B_s, ctx_B_s;
    logic [C_length-1:0]   wr_C_s, ctx_C_s;
    logic [N_length-1:0]   wr_N_s, ctx_N_s;
    logic [Nn_length-1:0]  wr_Nn_s, ctx_Nn_s;

    assign hazard_s = upd_valid && (upd_q == req_q);
    // Reset masks every memory strobe so nothing is written while rst is held.
    assign req_ready = rst ? 1'b0 : ready_s;
    assign accept_s  = req_valid && req_ready;

    // Next-state and memory-port decode for the INIT sweep and RUN service.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        ready_s     = 1'b0;
        wr_code_s   = '0;
        wr_q_s      = upd_q;
        wr_A_s      = upd_A;
        wr_B_s      = upd_B;
        wr_C_s      = upd_C;
        wr_N_s      = upd_N;
        wr_Nn_s     = upd_Nn;
        case (state_r)
            ST_INIT: begin
                wr_code_s = MASK_ALL;
                wr_q_s    = cnt_r;
                wr_A_s    = A_length'(A_INIT);
                wr_B_s    = '0;
                wr_C_s    = '0;
                wr_N_s    = N_length'(N_INIT);
                wr_Nn_s   = '0;
                if (scan_start) begin
                    cnt_nxt_s = '0;
                end else if (cnt_r == LAST_Q) begin
                    state_nxt_s = ST_RUN;
                    cnt_nxt_s   = '0;
                end else begin
                    cnt_nxt_s = cnt_r + Q_length'(1);
                end
            end
            ST_RUN: begin
`ifdef CTX_FWD_EN
                ready_s = 1'b1;
`else
                ready_s = !hazard_s;
`endif
                if (upd_valid) begin
                    wr_code_s = upd_mask;
                end else begin
                    wr_code_s = '0;
                end
                if (scan_start) begin
                    state_nxt_s = ST_INIT;
                    cnt_nxt_s   = '0;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            default: begin
                state_nxt_s = ST_INIT;
                cnt_nxt_s   = '0;
            end
        endcase
    end

    assign mem.mem_read     = accept_s;
    assign mem.mem_Q_Read   = accept_s ? req_q : '0;
    assign mem.mem_write    = rst ? '0 : wr_code_s;
    assign mem.mem_Q_Write  = wr_q_s;
    assign mem.mem_A_Write  = wr_A_s;
    assign mem.mem_B_Write  = wr_B_s;
    assign mem.mem_C_Write  = wr_C_s;
    assign mem.mem_N_Write  = wr_N_s;
    assign mem.mem_Nn_Write = wr_Nn_s;

    // FSM state, sweep counter and fetch pipeline registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_INIT;
            cnt_r       <= '0;
            init_done_r <= 1'b0;
            ctx_valid_r <= 1'b0;
            ctx_q_r     <= '0;
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            init_done_r <= (state_nxt_s == ST_RUN);
            ctx_valid_r <= accept_s;
            if (accept_s) begin
                ctx_q_r <= req_q;
            end else begin
                ctx_q_r <= ctx_q_r;
            end
        end
    end

`ifdef CTX_FWD_EN
    logic [Context_rw-1:0] fwd_mask_r;
    logic [A_length-1:0]   fwd_A_r;
    logic [B_length-1:0]   fwd_B_r;
    logic [C_length-1:0]   fwd_C_r;
    logic [N_length-1:0]   fwd_N_r;
    logic [Nn_length-1:0]  fwd_Nn_r;

    // Capture an update that hits the context being fetched in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            fwd_mask_r <= '0;
            fwd_A_r    <= '0;
            fwd_B_r    <= '0;
            fwd_C_r    <= '0;
            fwd_N_r    <= '0;
            fwd_Nn_r   <= '0;
        end else if (accept_s && hazard_s) begin
            fwd_mask_r <= upd_mask;
            fwd_A_r    <= upd_A;
            fwd_B_r    <= upd_B;
            fwd_C_r    <= upd_C;
            fwd_N_r    <= upd_N;
            fwd_Nn_r   <= upd_Nn;
        end else begin
            fwd_mask_r <= '0;
            fwd_A_r    <= fwd_A_r;
            fwd_B_r    <= fwd_B_r;
            fwd_C_r    <= fwd_C_r;
            fwd_N_r    <= fwd_N_r;
            fwd_Nn_r   <= fwd_Nn_r;
        end
    end
`endif

    // Fetched fields: memory read data, optionally overridden by forwarded fields.
    always_comb begin
        ctx_A_s  = '0;
        ctx_B_s  = '0;
        ctx_C_s  = '0;
        ctx_N_s  = '0;
        ctx_Nn_s = '0;
        if (ctx_valid_r) begin
`ifdef CTX_FWD_EN
            if (fwd_mask_r == MASK_ALL) begin
                ctx_A_s = fwd_A_r;
                ctx_N_s = fwd_N_r;
            end else begin
                ctx_A_s = mem.mem_A_Read;
                ctx_N_s = mem.mem_N_Read;
            end
            if (fwd_mask_r[0]) begin
                ctx_B_s = fwd_B_r;
                ctx_C_s = fwd_C_r;
            end else begin
                ctx_B_s = mem.mem_B_Read;
                ctx_C_s = mem.mem_C_Read;
            end
            if (fwd_mask_r[1]) begin
                ctx_Nn_s = fwd_Nn_r;
            end else begin
                ctx_Nn_s = mem.mem_Nn_Read;
            end
`else
            ctx_A_s  = mem.mem_A_Read;
            ctx_B_s  = mem.mem_B_Read;
            ctx_C_s  = mem.mem_C_Read;
            ctx_N_s  = mem.mem_N_Read;
            ctx_Nn_s = mem.mem_Nn_Read;
`endif
        end else begin
            ctx_A_s  = '0;
            ctx_B_s  = '0;
            ctx_C_s  = '0;
            ctx_N_s  = '0;
            ctx_Nn_s = '0;
        end
    end

    assign init_done = init_done_r;
    assign ctx_valid = ctx_valid_r;
    assign ctx_q     = ctx_q_r;
    assign ctx_A     = ctx_A_s;
    assign ctx_B     = ctx_B_s;
    assign ctx_C     = ctx_C_s;
    assign ctx_N     = ctx_N_s;
    assign ctx_Nn    = ctx_Nn_s;
endmodule
